led_pattern_ctl: RTL and testbench

LED_PATTERN_CTL -- requirements
Module: led_pattern_ctl

---
 rtl/led_pattern_ctl.sv | 149 ++++++++++++++
 tb/tb_led_pattern_ctl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctl.sv
// led_pattern_ctl: four-LED pattern generator with off, blink, running
// light and PWM breathing modes.
//   clk   - system clock, all state updates on the rising edge
//   rst   - asynchronous, active-high reset
//   ctrl  - mode select (0 off, 1 blink, 2 running, 3 breathing)
//   led   - registered LED drive, 1 = lit
module led_pattern_ctl #(
    parameter logic [23:0] TICK_CNT   = 24'd6_000_000,
    parameter logic [7:0]  BREATH_DIV = 8'd92
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ctrl,
    output logic [3:0] led
);

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_BLINK  = 2'd1,
        M_RUN    = 2'd2,
        M_BREATH = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    mode_e       mode_q, mode_d;
    logic [23:0] tick_cnt_q, tick_cnt_d;
    logic        phase_q, phase_d;
    logic [3:0]  pos_q, pos_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [7:0]  duty_q, duty_d;
    dir_e        dir_q, dir_d;
    logic [3:0]  led_q, led_d;

    logic chg;
    logic tick;
    logic pwm_wrap;
    logic div_done;

    assign chg      = (ctrl != mode_q);
    assign tick     = (tick_cnt_q == TICK_CNT - 24'd1);
    assign pwm_wrap = (pwm_cnt_q == 8'hFF);
    assign div_done = (div_cnt_q == BREATH_DIV - 8'd1);

    assign led = led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= M_OFF;
            tick_cnt_q <= '0;
            phase_q    <= 1'b0;
            pos_q      <= 4'b0001;
            pwm_cnt_q  <= '0;
            div_cnt_q  <= '0;
            duty_q     <= '0;
            dir_q      <= DIR_UP;
            led_q      <= '0;
        end else begin
            mode_q     <= mode_d;
            tick_cnt_q <= tick_cnt_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            pwm_cnt_q  <= pwm_cnt_d;
            div_cnt_q  <= div_cnt_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        mode_d     = mode_e'(ctrl);
        tick_cnt_d = tick_cnt_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        pwm_cnt_d  = pwm_cnt_q;
        div_cnt_d  = div_cnt_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        led_d      = led_q;

        if (chg) begin
            // Restart the pattern; led keeps its value for this one cycle
            // so neither the old nor a half-initialised pattern leaks out.
            tick_cnt_d = '0;
            phase_d    = 1'b0;
            pos_d      = 4'b0001;
            pwm_cnt_d  = '0;
            div_cnt_d  = '0;
            duty_d     = '0;
            dir_d      = DIR_UP;
        end else begin
            unique case (mode_q)
                M_OFF: begin
                    led_d = 4'b0000;
                end
                M_BLINK: begin
                    tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;
                    if (tick) begin
                        phase_d = ~phase_q;
                    end
                    led_d = {4{phase_q}};
                end
                M_RUN: begin
                    tick_cnt_d = tick ? 24'd0 : tick_cnt_q + 24'd1;
                    if (tick) begin
                        pos_d = {pos_q[2:0], pos_q[3]};
                    end
                    led_d = pos_q;
                end
                M_BREATH: begin
                    pwm_cnt_d = pwm_cnt_q + 8'd1;
                    led_d     = {4{pwm_cnt_q < duty_q}};
                    if (pwm_wrap) begin
                        if (div_done) begin
                            div_cnt_d = '0;
                            // Reverse at the ends instead of wrapping.
                            if (dir_q == DIR_UP) begin
                                if (duty_q == 8'hFF) begin
                                    dir_d  = DIR_DN;
                                    duty_d = 8'hFE;
                                end else begin
                                    duty_d = duty_q + 8'd1;
                                end
                            end else begin
                                if (duty_q == 8'h00) begin
                                    dir_d  = DIR_UP;
                                    duty_d = 8'h01;
                                end else begin
                                    duty_d = duty_q - 8'd1;
                                end
                            end
                        end else begin
                            div_cnt_d = div_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    led_d = 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_ctl.sv
// tb_led_pattern_ctl: directed scoreboard bench for led_pattern_ctl
// (TICK_CNT=4, BREATH_DIV=1), two instances sharing clk and ctrl.
module tb_led_pattern_ctl;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [1:0] ctrl;
    logic [3:0] led_a;
    logic [3:0] led_b;

    int total = 0;
    int bad   = 0;

    logic [3:0] expq[$];
    int         cntq[$];

    always #5 clk = ~clk;

    led_pattern_ctl #(.TICK_CNT(24'd4), .BREATH_DIV(8'd1)) dut_a (
        .clk  (clk),
        .rst  (rst_a),
        .ctrl (ctrl),
        .led  (led_a)
    );

    led_pattern_ctl #(.TICK_CNT(24'd4), .BREATH_DIV(8'd1)) dut_b (
        .clk  (clk),
        .rst  (rst_b),
        .ctrl (ctrl),
        .led  (led_b)
    );

    task automatic push(input logic [3:0] v, input int n);
        repeat (n) expq.push_back(v);
    endtask

    task automatic drain(input string tag);
        logic [3:0] e;
        while (expq.size() > 0) begin
            @(negedge clk);
            e = expq.pop_front();
            total++;
            assert (led_a === e) else begin
                bad++;
                $error("FAIL %s led=%b exp=%b", tag, led_a, e);
            end
        end
    endtask

    initial begin
        int ca;
        int cb;
        int e;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ctrl  = 2'd0;
        repeat (3) @(negedge clk);
        total++;
        assert (led_a === 4'b0000) else begin
            bad++;
            $error("FAIL reset led=%b exp=0000", led_a);
        end

        // Release with running mode held.
        ctrl  = 2'd2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        push(4'b0000, 1);
        push(4'b0001, 4);
        push(4'b0010, 4);
        push(4'b0100, 4);
        push(4'b1000, 4);
        push(4'b0001, 4);
        drain("run");
        push(4'b0010, 4);
        push(4'b0100, 1);
        drain("run2");

        // 2 -> 1 -> 2 on consecutive edges at led=0100.
        ctrl = 2'd1;
        push(4'b0100, 1);
        drain("glitch");
        ctrl = 2'd2;
        push(4'b0100, 1);
        push(4'b0001, 4);
        push(4'b0010, 1);
        drain("restart");

        ctrl = 2'd0;
        push(4'b0010, 1);
        push(4'b0000, 6);
        drain("off");

        ctrl = 2'd1;
        push(4'b0000, 5);
        push(4'b1111, 4);
        push(4'b0000, 4);
        push(4'b1111, 4);
        drain("blink");

        ctrl = 2'd0;
        push(4'b1111, 1);
        push(4'b0000, 3);
        drain("quiet");

        ctrl = 2'd3;
        push(4'b0000, 1);
        drain("breath_start");

        for (int p = 0; p < 258; p++) begin
            ca = 0;
            cb = 0;
            cntq.push_back(p <= 255 ? p : 510 - p);
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (led_a == 4'hF) ca++;
                if (led_b == 4'hF) cb++;
                if (p == 100 && i == 10) begin
                    #1 rst_b = 1'b1;
                    #1;
                    total++;
                    assert (led_b === 4'b0000) else begin
                        bad++;
                        $error("FAIL async_rst led=%b exp=0000", led_b);
                    end
                end
                if (p == 100 && i == 254) rst_b = 1'b0;
            end
            e = cntq.pop_front();
            total++;
            assert (ca === e) else begin
                bad++;
                $error("FAIL breath p=%0d lit=%0d exp=%0d", p, ca, e);
            end
            if (p >= 101) begin
                total++;
                assert (cb === p - 101) else begin
                    bad++;
                    $error("FAIL breath_rst p=%0d lit=%0d exp=%0d",
                           p, cb, p - 101);
                end
            end
        end

        @(negedge clk);
        #2 rst_a = 1'b1;
        #1;
        total++;
        assert (led_a === 4'b0000) else begin
            bad++;
            $error("FAIL mid_rst led=%b exp=0000", led_a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
